// File: rtl/spi_ctrl_pkg.sv
// rtl/spi_ctrl_pkg.sv - shared state type and counter-width helper for the SPI TX sequencer
package spi_ctrl_pkg;

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} spi_seq_state_t;

    // One spare bit so a counter can hold its terminal value without truncation
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// rtl/spi_clk_div.sv - enable-gated divider giving a one-cycle tick every CLK_DIV cycles
module spi_clk_div
    import spi_ctrl_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = cnt_width(CLK_DIV);
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] div_cnt;

    assign tick = en && (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (clr || tick) begin
            div_cnt <= '0;
        end else if (en) begin
            div_cnt <= div_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/spi_tx_sequencer.sv
// rtl/spi_tx_sequencer.sv - mode-0 SPI master draining a TX FIFO, MSB first, with RX capture
module spi_tx_sequencer
    import spi_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 2,
    parameter int CS_GAP     = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  miso,
    output logic                  sclk,
    output logic                  mosi,
    output logic                  cs_n,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy
);

    localparam int BW = cnt_width(DATA_WIDTH);
    localparam int GW = cnt_width(CS_GAP);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);

    spi_seq_state_t state, state_d;

    logic [DATA_WIDTH-1:0] tx_shift;
    logic [DATA_WIDTH-1:0] rx_shift;
    logic [BW-1:0]         bit_cnt;
    logic [GW-1:0]         gap_cnt;
    logic                  tick;
    logic                  div_en;
    logic                  word_end;

    // Gated by rst_n so nothing is popped while the block is held in reset
    assign word_end   = (state == SHIFT) && tick && sclk && (bit_cnt == LAST_BIT);
    assign fifo_rd_en = rst_n && enable && !fifo_empty && ((state == IDLE) || word_end);
    assign div_en     = (state == SETUP) || (state == SHIFT) || (state == HOLD);

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (div_en),
        .clr   (state_d != state),
        .tick  (tick)
    );

    always_comb begin
        state_d = state;
        cs_n    = 1'b1;
        mosi    = 1'b0;
        busy    = (state != IDLE);
        case (state)
            IDLE: begin
                if (fifo_rd_en) state_d = SETUP;
            end
            SETUP: begin
                cs_n = 1'b0;
                mosi = tx_shift[DATA_WIDTH-1];
                if (tick) state_d = SHIFT;
            end
            SHIFT: begin
                cs_n = 1'b0;
                mosi = tx_shift[DATA_WIDTH-1];
                if (word_end && !fifo_rd_en) state_d = HOLD;
            end
            HOLD: begin
                cs_n = 1'b0;
                if (tick) state_d = GAP;
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sclk     <= 1'b0;
            tx_shift <= '0;
            rx_shift <= '0;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            state    <= state_d;
            rx_valid <= word_end;
            case (state)
                SHIFT: begin
                    if (tick) begin
                        sclk <= ~sclk;
                        if (!sclk) begin
                            rx_shift <= {rx_shift[DATA_WIDTH-2:0], miso};
                        end else begin
                            tx_shift <= tx_shift << 1;
                            bit_cnt  <= word_end ? '0 : bit_cnt + BW'(1);
                            if (word_end) rx_data <= rx_shift;
                        end
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt + GW'(1);
                end
                default: begin
                    sclk    <= 1'b0;
                    gap_cnt <= '0;
                end
            endcase
            // A pop (from IDLE or at word_end) overrides the shift with the new word
            if (fifo_rd_en) begin
                tx_shift <= fifo_rd_data;
                bit_cnt  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_spi_tx_sequencer.sv
// tb/tb_spi_tx_sequencer.sv - self-checking bench for spi_tx_sequencer with FIFO model and loopback
module tb_spi_tx_sequencer;

    localparam int DW = 8;
    localparam int CD = 2;
    localparam int CG = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          miso_tie = 1'b0;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data;
    logic          miso;
    logic          sclk;
    logic          mosi;
    logic          cs_n;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          busy;

    logic [DW-1:0] mem [0:63];
    int wr_ptr = 0;
    int skip = 0;
    int rd_total = 0;
    int rd_done = 0;
    int cyc = 0;
    int checks = 0;
    int errors = 0;

    int   rd_cyc[$];
    int   rx_cyc[$];
    int   cs_fall_q[$];
    int   cs_rise_q[$];
    logic [DW-1:0] rx_q[$];
    logic mosi_q[$];
    int   cs_low_t = 0;
    int   busy_hi_t = 0;
    int   viol_t = 0;
    logic prev_cs = 1'b1;
    logic prev_sclk = 1'b0;

    int rd_base, rx_base, mosi_base, csl_base, fall_base, rise_base, busy_base, viol_base;
    logic [DW-1:0] exp_w [0:7];

    assign fifo_empty   = (rd_done + skip) >= wr_ptr;
    assign fifo_rd_data = mem[6'((rd_done + skip) % 64)];
    assign miso         = miso_tie ? 1'b1 : mosi;

    always #5 clk = ~clk;

    spi_tx_sequencer #(.DATA_WIDTH(DW), .CLK_DIV(CD), .CS_GAP(CG)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .miso         (miso),
        .sclk         (sclk),
        .mosi         (mosi),
        .cs_n         (cs_n),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .busy         (busy)
    );

    // Pre-edge value of the Mealy read strobe is what the DUT acted on
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            rd_cyc.push_back(cyc);
            rd_total++;
        end
        cyc++;
    end

    always @(negedge clk) begin
        rd_done = rd_total;
        if (!cs_n) cs_low_t++;
        if (!cs_n && prev_cs) cs_fall_q.push_back(cyc);
        if (cs_n && !prev_cs) cs_rise_q.push_back(cyc);
        if (busy && cs_n) busy_hi_t++;
        if (!cs_n || sclk || busy) viol_t++;
        if (sclk && !prev_sclk) mosi_q.push_back(mosi);
        if (rx_valid) begin
            rx_q.push_back(rx_data);
            rx_cyc.push_back(cyc);
        end
        prev_cs   = cs_n;
        prev_sclk = sclk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] w);
        mem[wr_ptr % 64] = w;
        wr_ptr++;
    endtask

    task automatic mon_mark();
        rd_base   = rd_total;
        rx_base   = rx_q.size();
        mosi_base = mosi_q.size();
        csl_base  = cs_low_t;
        fall_base = cs_fall_q.size();
        rise_base = cs_rise_q.size();
        busy_base = busy_hi_t;
        viol_base = viol_t;
    endtask

    task automatic wait_idle();
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while ((busy || (enable && !fifo_empty)) && t < 3000);
        chk("idle_timeout", t < 3000, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_rises(input int n);
        int t = 0;
        while ((mosi_q.size() - mosi_base) < n && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("rise_timeout", t < 1000, 1);
    endtask

    // Expectations come straight from frame arithmetic: cs low = CD*(2*DW*n+2), 2*DW*CD per word
    task automatic check_frame(input int n, input bit tied);
        logic [DW-1:0] w;
        chk("rd_count", rd_total - rd_base, n);
        chk("cs_falls", cs_fall_q.size() - fall_base, 1);
        chk("cs_low_cycles", cs_low_t - csl_base, CD * (2 * DW * n + 2));
        chk("busy_in_gap", busy_hi_t - busy_base, CG);
        chk("rx_count", rx_q.size() - rx_base, n);
        chk("mosi_bits", mosi_q.size() - mosi_base, DW * n);
        for (int k = 0; k < n; k++) begin
            if (rx_base + k < rx_q.size())
                chk("rx_data", rx_q[rx_base + k], tied ? {DW{1'b1}} : exp_w[k]);
            if (mosi_base + (k + 1) * DW <= mosi_q.size()) begin
                w = '0;
                for (int i = 0; i < DW; i++) w = {w[DW-2:0], mosi_q[mosi_base + k * DW + i]};
                chk("mosi_word", w, exp_w[k]);
            end
            if (k == 0 && rd_base < rd_cyc.size() && fall_base < cs_fall_q.size())
                chk("rd_before_first_bit", rd_cyc[rd_base] + 1, cs_fall_q[fall_base]);
            if (k > 0 && rx_base + k < rx_cyc.size() && rd_base + k < rd_cyc.size()) begin
                chk("rx_spacing", rx_cyc[rx_base + k] - rx_cyc[rx_base + k - 1], 2 * DW * CD);
                chk("rd_at_word_end", rd_cyc[rd_base + k] + 1, rx_cyc[rx_base + k - 1]);
            end
        end
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_cs_n", cs_n, 1);
        chk("rst_sclk", sclk, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rd_en", fifo_rd_en, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single word 0xA5, loopback
        exp_w[0] = 8'hA5;
        mon_mark();
        push(8'hA5);
        enable = 1'b1;
        wait_idle();
        check_frame(1, 1'b0);

        // Three back-to-back words
        exp_w[0] = 8'h3C; exp_w[1] = 8'hFF; exp_w[2] = 8'h00;
        mon_mark();
        push(8'h3C); push(8'hFF); push(8'h00);
        wait_idle();
        check_frame(3, 1'b0);

        // Enabled but empty: fully quiet
        mon_mark();
        repeat (50) @(negedge clk);
        chk("empty_activity", viol_t - viol_base, 0);
        chk("empty_reads", rd_total - rd_base, 0);

        // Randomized frames
        for (int f = 0; f < 4; f++) begin
            n = $urandom_range(1, 4);
            mon_mark();
            for (int k = 0; k < n; k++) begin
                exp_w[k] = DW'($urandom);
                push(exp_w[k]);
            end
            wait_idle();
            check_frame(n, 1'b0);
        end

        // enable dropped during bit 3 of word 1
        exp_w[0] = DW'($urandom);
        mon_mark();
        push(exp_w[0]); push(DW'($urandom));
        wait_rises(3);
        enable = 1'b0;
        wait_idle();
        chk("drop_reads", rd_total - rd_base, 1);
        chk("drop_fifo_left", wr_ptr - rd_done - skip, 1);
        chk("drop_rx_count", rx_q.size() - rx_base, 1);
        if (rx_base < rx_q.size()) chk("drop_rx_data", rx_q[rx_base], exp_w[0]);
        if (rise_base < cs_rise_q.size() && rx_base < rx_cyc.size())
            chk("drop_cs_rise", cs_rise_q[rise_base] - rx_cyc[rx_base], CD);
        skip++;

        // Reset during bit 5; the next FIFO word starts a fresh frame
        exp_w[0] = DW'($urandom);
        mon_mark();
        push(DW'($urandom)); push(exp_w[0]);
        enable = 1'b1;
        wait_rises(5);
        rst_n = 1'b0;
        #1;
        chk("midrst_cs_n", cs_n, 1);
        chk("midrst_sclk", sclk, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_rx_valid", rx_valid, 0);
        @(negedge clk);
        chk("midrst_fifo_left", wr_ptr - rd_done - skip, 1);
        rst_n = 1'b1;
        mon_mark();
        wait_idle();
        check_frame(1, 1'b0);

        // miso tied high, word 0x00
        miso_tie = 1'b1;
        exp_w[0] = 8'h00;
        mon_mark();
        push(8'h00);
        wait_idle();
        check_frame(1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
